// File: rtl/pe_array_ctrl_if.sv
// Bundles the job-request, buffer-read, PE-control and result-write signals of pe_array_ctrl.
// The slave modport is the controller's view of the bundle; the master modport is its environment's view.
interface pe_array_ctrl_if #(
  parameter int unsigned ARRAY_DIM  = 4,
  parameter int unsigned ADDR_WIDTH = 8
);
  localparam int unsigned IdxW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

  logic                  start;
  logic [ADDR_WIDTH-1:0] cfg_len;
  logic [ADDR_WIDTH-1:0] cfg_base_inp;
  logic [ADDR_WIDTH-1:0] cfg_base_wgt;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr_inp;
  logic [ADDR_WIDTH-1:0] rd_addr_wgt;
  logic                  pe_en;
  logic                  acc_clr;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [IdxW-1:0]       wr_idx;

  modport master (
    output start, cfg_len, cfg_base_inp, cfg_base_wgt, wr_ready,
    input  busy, done, rd_en, rd_addr_inp, rd_addr_wgt, pe_en, acc_clr, wr_valid, wr_idx
  );

  modport slave (
    input  start, cfg_len, cfg_base_inp, cfg_base_wgt, wr_ready,
    output busy, done, rd_en, rd_addr_inp, rd_addr_wgt, pe_en, acc_clr, wr_valid, wr_idx
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// Job sequencer for a systolic PE array: streams K buffer reads, drains the array skew,
// then writes one result word per PE row under a valid/ready handshake.
module pe_array_ctrl #(
  parameter int unsigned ARRAY_DIM  = 4,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  pe_array_ctrl_if.slave  bus
);
  localparam int unsigned IdxW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_k;
  logic [ADDR_WIDTH-1:0] r_addr_inp;
  logic [ADDR_WIDTH-1:0] r_addr_wgt;
  logic [IdxW-1:0]       r_drain;
  logic [IdxW-1:0]       r_idx;
  logic                  r_pe_en;
  logic                  r_acc_clr;
  logic                  w_last_read;
  logic                  w_last_drain;
  logic                  w_last_idx;

  // r_k never exceeds len-1, so a full-range K fits the ADDR_WIDTH counter.
  assign w_last_read  = (r_k == (r_len - ADDR_WIDTH'(1)));
  assign w_last_drain = (r_drain == IdxW'(ARRAY_DIM - 1));
  assign w_last_idx   = (r_idx == IdxW'(ARRAY_DIM - 1));

  assign bus.rd_addr_inp = r_addr_inp;
  assign bus.rd_addr_wgt = r_addr_wgt;
  assign bus.pe_en       = r_pe_en;
  assign bus.acc_clr     = r_acc_clr;
  assign bus.wr_idx      = r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.rd_en    = 1'b0;
    bus.wr_valid = 1'b0;
    case (r_state)
      StIdle: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_state_next = (bus.cfg_len == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        bus.rd_en = 1'b1;
        if (w_last_read) w_state_next = StDrain;
      end
      StDrain: begin
        if (w_last_drain) w_state_next = StWrite;
      end
      StWrite: begin
        bus.wr_valid = 1'b1;
        if (bus.wr_ready && w_last_idx) w_state_next = StDone;
      end
      StDone: begin
        bus.done     = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_k        <= '0;
      r_addr_inp <= '0;
      r_addr_wgt <= '0;
      r_drain    <= '0;
      r_idx      <= '0;
      r_pe_en    <= 1'b0;
      r_acc_clr  <= 1'b0;
    end else begin
      // One-cycle buffer latency: PE consumes the data read in the previous cycle.
      r_pe_en   <= (r_state == StRead);
      r_acc_clr <= (r_state == StRead) && (r_k == '0);
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_len <= bus.cfg_len;
            r_k   <= '0;
            if (bus.cfg_len != '0) begin
              r_addr_inp <= bus.cfg_base_inp;
              r_addr_wgt <= bus.cfg_base_wgt;
            end
          end
        end
        StRead: begin
          // Stop advancing on the last read so the addresses hold the final one read.
          if (!w_last_read) begin
            r_k        <= r_k + ADDR_WIDTH'(1);
            r_addr_inp <= r_addr_inp + ADDR_WIDTH'(1);
            r_addr_wgt <= r_addr_wgt + ADDR_WIDTH'(1);
          end
        end
        StDrain: begin
          r_drain <= w_last_drain ? '0 : r_drain + IdxW'(1);
        end
        StWrite: begin
          if (bus.wr_ready) begin
            r_idx <= w_last_idx ? '0 : r_idx + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
